// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes, dump FSM state encoding and range-count helper
//            for the register file dump streamer.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int CNT_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EMIT0  = 3'd2,
        ST_EMIT1  = 3'd3,
        ST_FINISH = 3'd4
    } dump_state_e;

    // Inclusive register count from first to last, wrapping 31 -> 0.
    function automatic logic [CNT_W-1:0] range_count(
        input logic [ADDR_W-1:0] first,
        input logic [ADDR_W-1:0] last
    );
        logic [ADDR_W-1:0] span;
        span = last - first;
        return {1'b0, span} + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_range_ctr.sv
`default_nettype none
// ============================================================================
// Module   : dump_range_ctr
// Purpose  : Read pointer and remaining-beat counter for a register dump,
//            with load, pair advance (wrapping) and per-beat decrement.
// Revision : 1.0
// ============================================================================
module dump_range_ctr
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_first,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_advance,
    input  logic              i_consume,
    output logic [ADDR_W-1:0] o_ptr,
    output logic [ADDR_W-1:0] o_ptr_next,
    output logic              o_rem_is_one
);

    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_ptr <= i_first;
            r_rem <= i_count;
        end else begin
            // Address width equals log2 of the file size, so overflow wraps.
            if (i_advance) begin
                r_ptr <= r_ptr + ADDR_W'(2);
            end
            if (i_consume && (r_rem != '0)) begin
                r_rem <= r_rem - CNT_W'(1);
            end
        end
    end

    assign o_ptr        = r_ptr;
    assign o_ptr_next   = r_ptr + ADDR_W'(1);
    assign o_rem_is_one = (r_rem == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/regfile_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_streamer
// Purpose  : Walks a register address range two registers per fetch and
//            streams each register out on a valid/ready interface.
// Revision : 1.0
// ============================================================================
module regfile_dump_streamer
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int c_CNT_W = $clog2(NUM_REGS) + 1;

    localparam logic [2:0] c_S_IDLE   = ST_IDLE;
    localparam logic [2:0] c_S_FETCH  = ST_FETCH;
    localparam logic [2:0] c_S_EMIT0  = ST_EMIT0;
    localparam logic [2:0] c_S_EMIT1  = ST_EMIT1;
    localparam logic [2:0] c_S_FINISH = ST_FINISH;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;

    logic [DATA_W-1:0]  r_buf0;
    logic [DATA_W-1:0]  r_buf1;
    logic [ADDR_W-1:0]  r_addr0;
    logic [ADDR_W-1:0]  r_addr1;
    logic [ADDR_W-1:0]  r_rd_addr1;
    logic [ADDR_W-1:0]  r_rd_addr2;

    logic               w_load;
    logic               w_fetch;
    logic               w_emit0;
    logic               w_emit1;
    logic               w_hs;
    logic [c_CNT_W-1:0] w_count;
    logic [ADDR_W-1:0]  w_ptr;
    logic [ADDR_W-1:0]  w_ptr_p1;
    logic               w_rem_is_one;

    assign w_fetch = (r_state == c_S_FETCH);
    assign w_emit0 = (r_state == c_S_EMIT0);
    assign w_emit1 = (r_state == c_S_EMIT1);
    assign w_load  = (r_state == c_S_IDLE) && start;
    assign w_hs    = out_valid && out_ready;
    assign w_count = range_count(first_addr, last_addr);

    dump_range_ctr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (c_CNT_W)
    ) u_range_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_first      (first_addr),
        .i_count      (w_count),
        .i_advance    (w_fetch),
        .i_consume    (w_hs),
        .o_ptr        (w_ptr),
        .o_ptr_next   (w_ptr_p1),
        .o_rem_is_one (w_rem_is_one)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                w_state_nxt = c_S_EMIT0;
            end
            c_S_EMIT0: begin
                if (w_hs) begin
                    w_state_nxt = w_rem_is_one ? c_S_FINISH : c_S_EMIT1;
                end
            end
            c_S_EMIT1: begin
                if (w_hs) begin
                    w_state_nxt = w_rem_is_one ? c_S_FINISH : c_S_FETCH;
                end
            end
            c_S_FINISH: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Both registers are snapshotted in the FETCH cycle; an odd range simply
    // never emits the second slot of the last pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_addr0    <= '0;
            r_addr1    <= '0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= '0;
        end else if (w_fetch) begin
            r_buf0     <= rd_data1;
            r_buf1     <= rd_data2;
            r_addr0    <= w_ptr;
            r_addr1    <= w_ptr_p1;
            r_rd_addr1 <= w_ptr;
            r_rd_addr2 <= w_ptr_p1;
        end
    end

    assign rd_addr1 = w_fetch ? w_ptr    : r_rd_addr1;
    assign rd_addr2 = w_fetch ? w_ptr_p1 : r_rd_addr2;

    always_comb begin
        out_data = '0;
        out_addr = '0;
        if (w_emit0) begin
            out_data = r_buf0;
            out_addr = r_addr0;
        end else if (w_emit1) begin
            out_data = r_buf1;
            out_addr = r_addr1;
        end
    end

    assign out_valid = w_emit0 || w_emit1;
    assign out_last  = out_valid && w_rem_is_one;
    assign busy      = w_fetch || w_emit0 || w_emit1;
    assign done      = (r_state == c_S_FINISH);

endmodule
`default_nettype wire

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Read-side client of the 32x32 register file (two async read ports, one sync write port).
- On a start pulse, walks a contiguous register address range, reading two registers per fetch through both read ports.
- Emits each register as one beat on a valid/ready output stream, tagged with its address and a last flag.
- Used for debug readout and for dumping feature/state registers to downstream logic.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, register count; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  in  ADDR_W  first register to dump; sampled with start.
- last_addr  in  ADDR_W  last register to dump, inclusive; sampled with start.
- rd_addr1  out  ADDR_W  drives register file read port 1 address.
- rd_addr2  out  ADDR_W  drives register file read port 2 address.
- rd_data1  in  DATA_W  register file read port 1 data (combinational).
- rd_data2  in  DATA_W  register file read port 2 data (combinational).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  register contents.
- out_addr  out  ADDR_W  address of out_data.
- out_last  out  1  high on the final beat of the dump.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset (async, takes effect immediately):
  - FSM goes to IDLE.
  - All outputs are 0: rd_addr1/2, out_*, busy, done.
  - Internal pointer, remaining count and capture buffer are cleared.
- Range setup:
  - count = ((last_addr - first_addr) mod NUM_REGS) + 1, so the range is 1..32.
  - last_addr < first_addr wraps 31 -> 0, e.g. first=30, last=1 dumps 30,31,0,1.
  - first_addr == last_addr dumps exactly one register.
- FSM states: IDLE, FETCH, EMIT0, EMIT1, FINISH.
  - IDLE: start=1 latches ptr=first_addr and rem=count, then goes to FETCH. busy rises the next cycle.
  - FETCH:
    - rd_addr1=ptr, rd_addr2=ptr+1 (mod 32).
    - At the clock edge, captures rd_data1/rd_data2 into buf0/buf1 and addresses ptr/ptr+1.
    - ptr += 2 (mod 32), then goes to EMIT0.
  - EMIT0:
    - out_valid=1, out_data=buf0, out_addr=addr0, out_last=(rem==1).
    - On handshake, rem -= 1.
    - Next state: FINISH if rem was 1; else EMIT1.
  - EMIT1:
    - out_valid=1, out_data=buf1, out_last=(rem==1).
    - On handshake, rem -= 1.
    - Next state: FINISH if rem was 1; else FETCH.
  - FINISH: done=1 for one cycle, busy=0, then goes to IDLE.
- Handshake rules:
  - A beat transfers when out_valid && out_ready at the rising edge.
  - While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Odd count: the final FETCH reads one extra register on port 2, which is discarded and never emitted.
- Latency:
  - The first beat is valid 2 cycles after the start edge (IDLE->FETCH, FETCH->EMIT0).
  - Throughput is 2 beats per 3 cycles with out_ready held high.
  - A 32-register dump takes 48 cycles plus FINISH.
- Snapshot: each register is sampled in its FETCH cycle. Writes to the file landing after that cycle are not reflected; writes landing before it are.
- start while busy is ignored, with no queueing.
- rd_addr1/2 are driven only in FETCH and hold their last value otherwise.
- Reset mid-dump aborts immediately: no done pulse, and the stream is truncated.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS constants.
  - The dump FSM state enum.
  - A range-count function (mod arithmetic).
- Natural sub-module: dump_range_ctr (ptr/rem counter with wrap and load). Everything else stays in the top-level block.

Test Plan:
- Full dump: file preloaded with reg[i]=32'hA500_0000+i; start first=0, last=31, ready=1 -> 32 beats, addr 0..31, data A5000000..A500001F, out_last only on addr 31, done 1 cycle after, busy low after.
- Odd/wrap range: first=30, last=2 -> 5 beats with addresses 30,31,0,1,2; the dummy read of addr 3 is never emitted; out_last on addr 2.
- Single register: first=last=7 -> exactly 1 beat, addr 7, out_last=1, then FINISH; done pulse 3 cycles after the start edge (one beat).
- Backpressure: hold out_ready=0 for 5 cycles on beat 2 -> out_data/addr stable throughout, no beat lost or duplicated, and data order is unchanged when ready returns.
- start during busy plus snapshot: a second start mid-dump is ignored. Write reg[20]=32'hDEAD_BEEF during the FETCH cycle of 18/19 -> reg[20] beat shows DEADBEEF. A write to reg[0] after its fetch is not shown.
- Async reset mid-dump: assert rst between clock edges during EMIT1 -> out_valid, busy and done are 0 immediately, with no done pulse. After release, a new start dumps correctly from first_addr.
